bulk_xfer_initiator: RTL and testbench

//  Drives the bulk-endpoint side of the USB transaction-layer interface from the link end:
//  it issues bulk IN/OUT transfers to an endpoint pair (IN FIFO / OUT FIFO) and moves the data to/from AXIS.
//  It is the initiator counterpart of the bulk endpoints. It is used for on-chip loopback self-test and for

---
 rtl/bulk_xfer_initiator.sv | 150 +++++++++++++++
 tb/tb_bulk_xfer_initiator.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_xfer_initiator.sv
// bulk_xfer_initiator
// Link-side initiator for a bulk IN/OUT endpoint pair. It moves IN bytes from the
// endpoint onto an AXIS master and OUT bytes from an AXIS slave into the endpoint.
// Used for on-chip loopback self-test and for bring-up without a USB host.

module bulk_xfer_initiator #(
  parameter bit HIGH_SPEED = 1'b1,
  parameter int MAX_PACKET = HIGH_SPEED ? 512 : 64,
  parameter int GAP_CYCLES = 4,
  parameter int IN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  // bulk IN side
  output logic       blk_in_xfer_o,
  input  logic       blk_xfer_in_has_data_i,
  input  logic [7:0] blk_xfer_in_data_i,
  input  logic       blk_xfer_in_data_valid_i,
  output logic       blk_xfer_in_data_ready_o,
  input  logic       blk_xfer_in_data_last_i,
  // bulk OUT side
  output logic       blk_out_xfer_o,
  input  logic       blk_xfer_out_ready_read_i,
  output logic [7:0] blk_xfer_out_data_o,
  output logic       blk_xfer_out_data_valid_o,
  // OUT data source
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  // IN data sink
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       in_timeout_o
);

  localparam int CNT_W  = $clog2(MAX_PACKET + 1);
  localparam int IDLE_W = $clog2(IN_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, IN_XFER, OUT_XFER, GAP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_was_in;
  logic              out_done;

  logic in_req;
  logic out_req;
  logic pick_in;
  logic cnt_at_max;
  logic in_hs;
  logic in_end;
  logic in_expire;
  logic out_hs;
  logic out_end;

  // Request decode, round-robin pick and per-beat handshake/end conditions
  always_comb begin
    in_req     = enable_i & blk_xfer_in_has_data_i & m_axis_tready;
    out_req    = enable_i & blk_xfer_out_ready_read_i & s_axis_tvalid;
    pick_in    = in_req & (~out_req | ~last_was_in);
    cnt_at_max = (cnt == CNT_W'(MAX_PACKET - 1));
    in_hs      = (state == IN_XFER) & blk_xfer_in_data_valid_i & m_axis_tready;
    in_end     = in_hs & (blk_xfer_in_data_last_i | cnt_at_max);
    in_expire  = (state == IN_XFER) & ~in_hs & (idle_cnt == IDLE_W'(IN_TIMEOUT - 1));
    out_hs     = (state == OUT_XFER) & ~out_done & s_axis_tvalid;
    out_end    = out_hs & (s_axis_tlast | cnt_at_max);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; OUT lingers one cycle after its end beat so the last strobe lands inside it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_in)      state_nxt = IN_XFER;
        else if (out_req) state_nxt = OUT_XFER;
      end
      IN_XFER:  if (in_end || in_expire) state_nxt = GAP;
      OUT_XFER: if (out_done) state_nxt = GAP;
      GAP:      if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; IN data path is a gated combinational pass-through
  always_comb begin
    blk_in_xfer_o            = (state == IN_XFER);
    blk_out_xfer_o           = (state == OUT_XFER);
    blk_xfer_in_data_ready_o = (state == IN_XFER) & m_axis_tready;
    m_axis_tvalid            = (state == IN_XFER) & blk_xfer_in_data_valid_i;
    m_axis_tdata             = (state == IN_XFER) ? blk_xfer_in_data_i : 8'h00;
    m_axis_tlast             = (state == IN_XFER) & (blk_xfer_in_data_last_i | cnt_at_max);
    s_axis_tready            = (state == OUT_XFER) & ~out_done;
  end

  // Beat counter, idle/gap counters, arbiter memory and OUT end flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idle_cnt    <= '0;
      gap_cnt     <= '0;
      last_was_in <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      if (state != GAP && state_nxt == GAP) cnt <= '0;
      else if (in_hs || out_hs)             cnt <= cnt + CNT_W'(1);

      if (state != IN_XFER || in_hs) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + IDLE_W'(1);

      if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else              gap_cnt <= '0;

      if (state == IDLE && state_nxt == IN_XFER)       last_was_in <= 1'b1;
      else if (state == IDLE && state_nxt == OUT_XFER) last_was_in <= 1'b0;

      if (state != OUT_XFER) out_done <= 1'b0;
      else if (out_end)      out_done <= 1'b1;
    end
  end

  // Registered OUT byte strobe (one cycle after the AXIS handshake) and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_xfer_out_data_o       <= 8'h00;
      blk_xfer_out_data_valid_o <= 1'b0;
      in_timeout_o              <= 1'b0;
    end else begin
      blk_xfer_out_data_valid_o <= out_hs;
      if (out_hs) blk_xfer_out_data_o <= s_axis_tdata;
      in_timeout_o <= in_expire;
    end
  end

  xfer_exclusive: assert property (@(posedge clk) !(blk_in_xfer_o && blk_out_xfer_o));

endmodule

// File: tb/tb_bulk_xfer_initiator.sv
// tb_bulk_xfer_initiator
// Directed bench: a table of IDLE request vectors plus hand-written multi-cycle sequences.

module tb_bulk_xfer_initiator;

  localparam int MAX_PACKET = 512;
  localparam int GAP_CYCLES = 4;
  localparam int IN_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       blk_in_xfer_o;
  logic       blk_xfer_in_has_data_i = 1'b0;
  logic [7:0] blk_xfer_in_data_i = 8'h00;
  logic       blk_xfer_in_data_valid_i = 1'b0;
  logic       blk_xfer_in_data_ready_o;
  logic       blk_xfer_in_data_last_i = 1'b0;
  logic       blk_out_xfer_o;
  logic       blk_xfer_out_ready_read_i = 1'b0;
  logic [7:0] blk_xfer_out_data_o;
  logic       blk_xfer_out_data_valid_o;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tlast = 1'b0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic       in_timeout_o;

  always #5 clk = ~clk;

  bulk_xfer_initiator #(
    .HIGH_SPEED(1'b1),
    .MAX_PACKET(MAX_PACKET),
    .GAP_CYCLES(GAP_CYCLES),
    .IN_TIMEOUT(IN_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(enable_i),
    .blk_in_xfer_o(blk_in_xfer_o),
    .blk_xfer_in_has_data_i(blk_xfer_in_has_data_i),
    .blk_xfer_in_data_i(blk_xfer_in_data_i),
    .blk_xfer_in_data_valid_i(blk_xfer_in_data_valid_i),
    .blk_xfer_in_data_ready_o(blk_xfer_in_data_ready_o),
    .blk_xfer_in_data_last_i(blk_xfer_in_data_last_i),
    .blk_out_xfer_o(blk_out_xfer_o),
    .blk_xfer_out_ready_read_i(blk_xfer_out_ready_read_i),
    .blk_xfer_out_data_o(blk_xfer_out_data_o),
    .blk_xfer_out_data_valid_o(blk_xfer_out_data_valid_o),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .in_timeout_o(in_timeout_o)
  );

  typedef struct {
    logic en;
    logic has_data;
    logic m_ready;
    logic ready_read;
    logic s_valid;
    logic exp_in;
    logic exp_out;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   ntrans;
  int   lens[8];

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    enable_i = 1'b0;
    blk_xfer_in_has_data_i = 1'b0;
    blk_xfer_in_data_i = 8'h00;
    blk_xfer_in_data_valid_i = 1'b0;
    blk_xfer_in_data_last_i = 1'b0;
    blk_xfer_out_ready_read_i = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply one IDLE request vector from a fresh reset and check which transfer starts
  task automatic applyStimulus(input vec_t v, input int i);
    doReset();
    enable_i = v.en;
    blk_xfer_in_has_data_i = v.has_data;
    m_axis_tready = v.m_ready;
    blk_xfer_out_ready_read_i = v.ready_read;
    s_axis_tvalid = v.s_valid;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_in_xfer", i), blk_in_xfer_o, v.exp_in);
    checkOutput($sformatf("vec%0d_out_xfer", i), blk_out_xfer_o, v.exp_out);
  endtask

  // Feed one n-byte source packet through OUT, checking strobe latency and data,
  // and recording the length of every OUT transfer it is split into
  task automatic outStream(input int n, input logic [7:0] base);
    int         idx = 0;
    bit         hs_prev = 1'b0;
    logic [7:0] d_prev = 8'h00;
    bit         xfer_prev = 1'b0;
    bit         valid_prev = 1'b0;
    int         cur_len = 0;
    bit         done = 1'b0;
    ntrans = 0;
    enable_i = 1'b1;
    blk_xfer_out_ready_read_i = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checkOutput("out_valid_latency", blk_xfer_out_data_valid_o, hs_prev);
      if (hs_prev) checkOutput("out_data", blk_xfer_out_data_o, d_prev);
      if (blk_xfer_out_data_valid_o) begin
        checkOutput("out_valid_inside_xfer", blk_out_xfer_o, 1);
        cur_len++;
      end
      if (xfer_prev && !blk_out_xfer_o) begin
        checkOutput("out_fall_after_final_pulse", valid_prev, 1);
        if (ntrans < 8) lens[ntrans] = cur_len;
        ntrans++;
        cur_len = 0;
      end
      if (idx == n && !blk_out_xfer_o && !blk_xfer_out_data_valid_o) begin
        done = 1'b1;
        break;
      end
      s_axis_tvalid = (idx < n);
      s_axis_tdata = base + idx[7:0];
      s_axis_tlast = (idx == n - 1);
      #1;
      hs_prev = s_axis_tvalid && s_axis_tready;
      d_prev = s_axis_tdata;
      if (hs_prev) idx++;
      xfer_prev = blk_out_xfer_o;
      valid_prev = blk_xfer_out_data_valid_o;
    end
    checkOutput("out_stream_complete", done, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    blk_xfer_out_ready_read_i = 1'b0;
  endtask

  initial begin
    int idx;
    int hi;
    int pulses;
    bit seen;
    bit done;
    bit tog;
    int order[8];
    int gaps[8];
    int nord;
    int ngap;
    int low;
    bit seen_any;
    bit prev_in;
    bit prev_out;
    int exp_order[4];

    //            en has mrdy rr  sval  in  out
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state with every input driven active
    rst = 1'b1;
    enable_i = 1'b1;
    blk_xfer_in_has_data_i = 1'b1;
    blk_xfer_in_data_i = 8'h5A;
    blk_xfer_in_data_valid_i = 1'b1;
    blk_xfer_in_data_last_i = 1'b1;
    blk_xfer_out_ready_read_i = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'hC3;
    s_axis_tlast = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_xfer", blk_in_xfer_o, 0);
    checkOutput("rst_out_xfer", blk_out_xfer_o, 0);
    checkOutput("rst_in_ready", blk_xfer_in_data_ready_o, 0);
    checkOutput("rst_out_data", blk_xfer_out_data_o, 0);
    checkOutput("rst_out_valid", blk_xfer_out_data_valid_o, 0);
    checkOutput("rst_s_tready", s_axis_tready, 0);
    checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_m_tdata", m_axis_tdata, 0);
    checkOutput("rst_m_tlast", m_axis_tlast, 0);
    checkOutput("rst_timeout", in_timeout_o, 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // OUT 3-byte packet A1..A3, then the gap with a new request pending
    doReset();
    outStream(3, 8'hA1);
    checkOutput("out3_transfers", ntrans, 1);
    checkOutput("out3_len", lens[0], 3);
    blk_xfer_out_ready_read_i = 1'b1;
    enable_i = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < GAP_CYCLES - 1; k++) begin
      @(negedge clk);
      checkOutput("out3_gap_low", blk_out_xfer_o, 0);
    end

    // OUT 1030-byte source packet splits into 512 + 512 + 6
    doReset();
    outStream(1030, 8'h00);
    checkOutput("out1030_transfers", ntrans, 3);
    checkOutput("out1030_len0", lens[0], 512);
    checkOutput("out1030_len1", lens[1], 512);
    checkOutput("out1030_len2", lens[2], 6);

    // Reset mid-OUT after 10 of 40 bytes, then a fresh transfer counts from zero
    doReset();
    enable_i = 1'b1;
    blk_xfer_out_ready_read_i = 1'b1;
    idx = 0;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (idx == 10) begin
        done = 1'b1;
        break;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = idx[7:0];
      s_axis_tlast = 1'b0;
      #1;
      if (s_axis_tvalid && s_axis_tready) idx++;
    end
    checkOutput("midrst_reached_10", done, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_xfer", blk_out_xfer_o, 0);
    checkOutput("midrst_out_valid", blk_xfer_out_data_valid_o, 0);
    checkOutput("midrst_s_tready", s_axis_tready, 0);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    blk_xfer_out_ready_read_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_idle", blk_out_xfer_o, 0);
    outStream(600, 8'h40);
    checkOutput("midrst_transfers", ntrans, 2);
    checkOutput("midrst_len0", lens[0], 512);
    checkOutput("midrst_len1", lens[1], 88);

    // IN: 5 bytes ending with last, sink ready toggling 1/0
    doReset();
    enable_i = 1'b1;
    blk_xfer_in_has_data_i = 1'b1;
    m_axis_tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (blk_in_xfer_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("in5_start", seen, 1);
    idx = 0;
    tog = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (idx == 5) break;
      blk_xfer_in_data_valid_i = 1'b1;
      blk_xfer_in_data_i = 8'h30 + idx[7:0];
      blk_xfer_in_data_last_i = (idx == 4);
      m_axis_tready = tog;
      tog = !tog;
      #1;
      checkOutput("in5_ready_passthru", blk_xfer_in_data_ready_o, m_axis_tready);
      checkOutput("in5_tvalid", m_axis_tvalid, 1);
      checkOutput("in5_tdata", m_axis_tdata, blk_xfer_in_data_i);
      if (m_axis_tready) begin
        checkOutput("in5_tlast", m_axis_tlast, idx == 4);
        idx++;
      end
      @(negedge clk);
    end
    blk_xfer_in_data_valid_i = 1'b0;
    blk_xfer_in_data_last_i = 1'b0;
    blk_xfer_in_has_data_i = 1'b0;
    checkOutput("in5_beats", idx, 5);
    checkOutput("in5_xfer_fell", blk_in_xfer_o, 0);

    // IN without last: tlast fabricated on beat 512; has_data dropping mid-way is ignored
    doReset();
    enable_i = 1'b1;
    blk_xfer_in_has_data_i = 1'b1;
    m_axis_tready = 1'b1;
    blk_xfer_in_data_valid_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (blk_in_xfer_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("in512_start", seen, 1);
    idx = 0;
    done = 1'b0;
    for (int c = 0; c < 700; c++) begin
      blk_xfer_in_data_i = idx[7:0];
      #1;
      checkOutput("in512_tlast", m_axis_tlast, idx == MAX_PACKET - 1);
      idx++;
      if (idx == 100) blk_xfer_in_has_data_i = 1'b0;
      @(negedge clk);
      if (!blk_in_xfer_o) begin
        done = 1'b1;
        break;
      end
    end
    blk_xfer_in_data_valid_i = 1'b0;
    checkOutput("in512_ended", done, 1);
    checkOutput("in512_beats", idx, MAX_PACKET);

    // IN timeout: has_data with no valid for IN_TIMEOUT cycles
    doReset();
    enable_i = 1'b1;
    blk_xfer_in_has_data_i = 1'b1;
    m_axis_tready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (blk_in_xfer_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("tmo_start", seen, 1);
    hi = 1;
    pulses = 0;
    done = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (in_timeout_o) begin
        pulses++;
        checkOutput("tmo_with_fall", blk_in_xfer_o, 0);
      end
      if (blk_in_xfer_o) hi++;
      else if (!done) begin
        done = 1'b1;
        blk_xfer_in_has_data_i = 1'b0;
      end
    end
    checkOutput("tmo_fell", done, 1);
    checkOutput("tmo_high_cycles", hi, IN_TIMEOUT);
    checkOutput("tmo_pulses", pulses, 1);

    // Both sides requesting continuously: round-robin with gaps, never both active
    doReset();
    enable_i = 1'b1;
    blk_xfer_in_has_data_i = 1'b1;
    m_axis_tready = 1'b1;
    blk_xfer_in_data_valid_i = 1'b1;
    blk_xfer_in_data_last_i = 1'b1;
    blk_xfer_in_data_i = 8'h11;
    blk_xfer_out_ready_read_i = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b1;
    s_axis_tdata = 8'h77;
    nord = 0;
    ngap = 0;
    low = 0;
    seen_any = 1'b0;
    prev_in = 1'b0;
    prev_out = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checkOutput("alt_exclusive", blk_in_xfer_o && blk_out_xfer_o, 0);
      if (blk_in_xfer_o && !prev_in) begin
        if (nord < 8) order[nord] = 1;
        nord++;
        if (seen_any && ngap < 8) begin
          gaps[ngap] = low;
          ngap++;
        end
        seen_any = 1'b1;
      end
      if (blk_out_xfer_o && !prev_out) begin
        if (nord < 8) order[nord] = 2;
        nord++;
        if (seen_any && ngap < 8) begin
          gaps[ngap] = low;
          ngap++;
        end
        seen_any = 1'b1;
      end
      if (!blk_in_xfer_o && !blk_out_xfer_o) low++;
      else low = 0;
      prev_in = blk_in_xfer_o;
      prev_out = blk_out_xfer_o;
    end
    idleInputs();
    exp_order = '{1, 2, 1, 2};
    checkOutput("alt_enough_transfers", nord >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < nord) checkOutput($sformatf("alt_order%0d", k), order[k], exp_order[k]);
      if (k < 3 && k < ngap) checkOutput($sformatf("alt_gap%0d", k), gaps[k], GAP_CYCLES + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
